combi_regfile: RTL

COMBI_REGFILE -- requirements
Module: combi_regfile

---
 rtl/combi_pkg.sv | 17 +
 rtl/regfile_rdport.sv | 28 ++
 rtl/combi_regfile.sv | 73 +++++++
 3 files changed

// File: rtl/combi_pkg.sv
// rtl/combi_pkg.sv - shared ISA constants and index helpers for the combined RV/ARM register file
package combi_pkg;

  localparam logic [4:0] RV_ZERO_REG  = 5'd0;
  localparam logic [4:0] ARM_PC_REG   = 5'd15;
  localparam logic [3:0] ARM_IDX_MASK = 4'hF;

  // ARM only addresses R0..R15, so bit 4 of any index is dropped in that mode
  function automatic logic [4:0] mask_idx(input logic arm, input logic [4:0] idx);
    return arm ? {1'b0, idx[3:0] & ARM_IDX_MASK} : idx;
  endfunction

  function automatic logic is_special(input logic arm, input logic [4:0] idx);
    return arm ? (idx == ARM_PC_REG) : (idx == RV_ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one read-port decoder: special register, then bypass, then stored value
module regfile_rdport
  import combi_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      idx,
  input  logic            arm,
  input  logic            byp_en,
  input  logic [4:0]      byp_idx,
  input  logic [XLEN-1:0] byp_data,
  input  logic [XLEN-1:0] pc_plus8,
  input  logic [XLEN-1:0] arr_data,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = arr_data;
    if (arm && idx == ARM_PC_REG) begin
      data = pc_plus8;
    end else if (!arm && idx == RV_ZERO_REG) begin
      data = '0;
    end else if (byp_en && byp_idx == idx) begin
      data = byp_data;
    end
  end

endmodule

// File: rtl/combi_regfile.sv
// rtl/combi_regfile.sv - RISC-V / ARM register file with write-first bypass and async reset
module combi_regfile
  import combi_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  input  logic [XLEN-1:0] PCPlus8,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2
);

  logic [XLEN-1:0] regs [NREGS];
  logic [4:0]      wr_idx;
  logic [4:0]      rd_idx1;
  logic [4:0]      rd_idx2;
  logic            wr_legal;
  logic            byp_en;
  logic [XLEN-1:0] arr1;
  logic [XLEN-1:0] arr2;

  assign wr_idx  = mask_idx(arm, RdW);
  assign rd_idx1 = mask_idx(arm, A1);
  assign rd_idx2 = mask_idx(arm, A2);

  // RegWriteW gates everything first so an X index or data while idle cannot leak into state
  assign wr_legal = RegWriteW && !is_special(arm, wr_idx) && (int'(wr_idx) < NREGS);
  assign byp_en   = wr_legal && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_legal) begin
      regs[wr_idx] <= ResultW;
    end
  end

  assign arr1 = (int'(rd_idx1) < NREGS) ? regs[rd_idx1] : '0;
  assign arr2 = (int'(rd_idx2) < NREGS) ? regs[rd_idx2] : '0;

  regfile_rdport #(.XLEN(XLEN)) u_rdport1 (
    .idx      (rd_idx1),
    .arm      (arm),
    .byp_en   (byp_en),
    .byp_idx  (wr_idx),
    .byp_data (ResultW),
    .pc_plus8 (PCPlus8),
    .arr_data (arr1),
    .data     (RD1)
  );

  regfile_rdport #(.XLEN(XLEN)) u_rdport2 (
    .idx      (rd_idx2),
    .arm      (arm),
    .byp_en   (byp_en),
    .byp_idx  (wr_idx),
    .byp_data (ResultW),
    .pc_plus8 (PCPlus8),
    .arr_data (arr2),
    .data     (RD2)
  );

endmodule
